// File: rtl/axis_frame_bridge.sv
// AXI-Stream to compute-core bridge: ping-pong input frame buffer, core handshake FSM,
// and output frame streamer with malformed-frame detection.
module axis_frame_bridge #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IN_DATA_NUM  = 8,
  parameter int unsigned OUT_DATA_NUM = 4,
  localparam int unsigned IN_ADR_W    = $clog2(IN_DATA_NUM),
  localparam int unsigned OUT_ADR_W   = $clog2(OUT_DATA_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  axisif_start,
  input  logic                  axisif_done,
  input  logic [IN_ADR_W-1:0]   axisif_bufferIn_adr,
  output logic [DATA_WIDTH-1:0] axisif_bufferIn_data,
  input  logic [OUT_ADR_W-1:0]  axisif_bufferOut_adr,
  input  logic [DATA_WIDTH-1:0] axisif_bufferOut_data,
  input  logic                  axisif_bufferOut_wr,
  output logic                  frame_err,
  output logic [15:0]           err_count
);

  typedef enum logic [2:0] {StIdle, StStart, StAck, StRun, StSend} state_e;

  localparam logic [IN_ADR_W-1:0]  WcntLast = IN_ADR_W'(IN_DATA_NUM - 1);
  localparam logic [OUT_ADR_W-1:0] RdLast   = OUT_ADR_W'(OUT_DATA_NUM - 1);

  logic [DATA_WIDTH-1:0] in_mem_q [2][IN_DATA_NUM];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DATA_NUM];

  state_e               state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic                 drain_q, drain_d;
  logic                 frame_err_q, frame_err_d;
  logic [IN_ADR_W-1:0]  wcnt_q, wcnt_d;
  logic [OUT_ADR_W-1:0] rd_q, rd_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 s_accept, in_wr, commit, bad_frame, bank_release;

  // Gated by rst so the slave sees not-ready while reset is held.
  assign s_ready  = ~rst & (~full_q[wbank_q] | drain_q);
  assign s_accept = s_valid & s_ready;
  assign in_wr    = s_accept & ~drain_q;

  // Input reception: runs independently of the core FSM.
  always_comb begin
    wbank_d   = wbank_q;
    wcnt_d    = wcnt_q;
    drain_d   = drain_q;
    commit    = 1'b0;
    bad_frame = 1'b0;
    if (s_accept) begin
      if (drain_q) begin
        if (s_last) begin
          drain_d   = 1'b0;
          bad_frame = 1'b1;
        end
      end else if (wcnt_q == WcntLast) begin
        commit  = 1'b1;
        wbank_d = ~wbank_q;
        wcnt_d  = '0;
        drain_d = ~s_last;
      end else if (s_last) begin
        wcnt_d    = '0;
        bad_frame = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    frame_err_d = bad_frame;
    err_count_d = (bad_frame && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end

  always_comb begin
    state_d      = state_q;
    rbank_d      = rbank_q;
    rd_d         = rd_q;
    bank_release = 1'b0;
    unique case (state_q)
      StIdle:  if (full_q[rbank_q]) state_d = StStart;
      StStart: state_d = StAck;
      StAck:   if (!axisif_done) state_d = StRun;
      StRun: begin
        if (axisif_done) begin
          state_d      = StSend;
          bank_release = 1'b1;
          rbank_d      = ~rbank_q;
          rd_d         = '0;
        end
      end
      StSend: begin
        if (m_ready) begin
          if (rd_q == RdLast) begin
            state_d = StIdle;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Released and committed banks are always distinct, so both updates apply.
    full_d = full_q;
    if (bank_release) full_d[rbank_q] = 1'b0;
    if (commit) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      drain_q     <= 1'b0;
      frame_err_q <= 1'b0;
      wcnt_q      <= '0;
      rd_q        <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      drain_q     <= drain_d;
      frame_err_q <= frame_err_d;
      wcnt_q      <= wcnt_d;
      rd_q        <= rd_d;
      err_count_q <= err_count_d;
    end
  end

  // Buffer storage carries no reset.
  always_ff @(posedge clk) begin
    if (in_wr) in_mem_q[wbank_q][wcnt_q] <= s_data;
    if (axisif_bufferOut_wr && (state_q == StAck || state_q == StRun)) begin
      out_mem_q[axisif_bufferOut_adr] <= axisif_bufferOut_data;
    end
  end

  assign axisif_bufferIn_data = in_mem_q[rbank_q][axisif_bufferIn_adr];
  assign axisif_start         = (state_q == StStart);
  assign m_valid              = (state_q == StSend);
  assign m_last               = m_valid && (rd_q == RdLast);
  assign m_data               = m_valid ? out_mem_q[rd_q] : '0;
  assign frame_err            = frame_err_q;
  assign err_count            = err_count_q;

endmodule

// File: tb/tb_axis_frame_bridge.sv
// Directed bench for axis_frame_bridge: frame table plus back-to-back, back-pressure
// and reset-in-SEND sequences against a behavioural core.
module tb_axis_frame_bridge;

  localparam int DW    = 32;
  localparam int IN_N  = 8;
  localparam int OUT_N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic          axisif_start;
  logic          axisif_done = 1'b1;
  logic [2:0]    in_adr = '0;
  logic [DW-1:0] in_data;
  logic [1:0]    out_adr = '0;
  logic [DW-1:0] out_data = '0;
  logic          out_wr = 1'b0;
  logic          frame_err;
  logic [15:0]   err_count;

  axis_frame_bridge #(.DATA_WIDTH(DW), .IN_DATA_NUM(IN_N), .OUT_DATA_NUM(OUT_N)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .axisif_start(axisif_start), .axisif_done(axisif_done),
    .axisif_bufferIn_adr(in_adr), .axisif_bufferIn_data(in_data),
    .axisif_bufferOut_adr(out_adr), .axisif_bufferOut_data(out_data),
    .axisif_bufferOut_wr(out_wr),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;

  always @(negedge clk) begin
    if (axisif_start) start_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int   t;
    logic rdy;
    t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    rdy = s_ready;
    while (!rdy && t < 200) begin
      @(posedge clk); #1;
      t++;
      rdy = s_ready;
    end
    if (!rdy) chk("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int nbeats, input int last_at);
    for (int b = 1; b <= nbeats; b++) send_beat(base + DW'(b - 1), b == last_at);
  endtask

  // Core model: reads all input words, writes out[j] = in[j] + 1 for the first OUT_N words.
  task automatic run_core(input logic [DW-1:0] base, input int hold);
    int t;
    t = 0;
    while (!axisif_start && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("start_seen", 32'(axisif_start), 1);
    axisif_done = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < IN_N; i++) begin
      in_adr = 3'(i);
      #1;
      chk("core_read", in_data, base + DW'(i));
      if (i < OUT_N) begin
        out_adr = 2'(i); out_data = in_data + 1; out_wr = 1'b1;
      end else begin
        out_wr = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_wr = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    axisif_done = 1'b1;
    @(posedge clk); #1;
    chk("send_entered", 32'(m_valid), 1);
  endtask

  // Collects OUT_N beats; optional alternating m_ready and an ignored write during SEND.
  task automatic consume(input logic [DW-1:0] base, input bit alt, input bit poke);
    int            k, cyc;
    bit            have_prev;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    k = 0; cyc = 0; have_prev = 0; prev_d = '0; prev_l = 1'b0;
    while (k < OUT_N && cyc < 200) begin
      m_ready = alt ? (cyc % 2 == 1) : 1'b1;
      if (poke && cyc == 0) begin
        out_adr = 2'(OUT_N - 1); out_data = 32'hDEAD; out_wr = 1'b1;
      end else begin
        out_wr = 1'b0;
      end
      if (m_valid) begin
        if (have_prev) begin
          chk("hold_data", m_data, prev_d);
          chk("hold_last", 32'(m_last), 32'(prev_l));
        end
        if (m_ready) begin
          chk("m_data", m_data, base + DW'(k + 1));
          chk("m_last", 32'(m_last), 32'(k == OUT_N - 1));
          k++;
          have_prev = 0;
        end else begin
          have_prev = 1; prev_d = m_data; prev_l = m_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_wr = 1'b0;
    m_ready = 1'b0;
    chk("beats_done", 32'(k), OUT_N);
    chk("m_valid_after", 32'(m_valid), 0);
  endtask

  typedef struct {
    int            nbeats;
    int            last_at;
    logic [DW-1:0] base;
    bit            proc;
    int            errs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int exp_err_total;
    int s0, e0, t;
    exp_err_total = 0;

    vecs[0] = '{nbeats: 8,  last_at: 8,  base: 32'h1,   proc: 1'b1, errs: 0};
    vecs[1] = '{nbeats: 5,  last_at: 5,  base: 32'h100, proc: 1'b0, errs: 1};
    vecs[2] = '{nbeats: 8,  last_at: 8,  base: 32'h200, proc: 1'b1, errs: 0};
    vecs[3] = '{nbeats: 10, last_at: 10, base: 32'h300, proc: 1'b1, errs: 1};
    vecs[4] = '{nbeats: 2,  last_at: 2,  base: 32'h400, proc: 1'b0, errs: 1};
    vecs[5] = '{nbeats: 7,  last_at: 7,  base: 32'h480, proc: 1'b0, errs: 1};
    vecs[6] = '{nbeats: 8,  last_at: 8,  base: 32'h500, proc: 1'b1, errs: 0};

    #12;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_start", 32'(axisif_start), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_m_data", m_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 1);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      s0 = start_cnt; e0 = ferr_cnt;
      fork
        send_frame(vecs[v].base, vecs[v].nbeats, vecs[v].last_at);
        begin
          if (vecs[v].proc) begin
            run_core(vecs[v].base, 0);
            consume(vecs[v].base, 1'b0, 1'b0);
          end else begin
            repeat (20) @(posedge clk);
            #1;
          end
        end
      join
      repeat (3) @(posedge clk);
      #1;
      exp_err_total += vecs[v].errs;
      chk("start_pulses", 32'(start_cnt - s0), vecs[v].proc ? 1 : 0);
      chk("frame_err_pulses", 32'(ferr_cnt - e0), 32'(vecs[v].errs));
      chk("err_count", 32'(err_count), 32'(exp_err_total));
    end

    // Back-to-back: third frame blocked until the first one leaves RUN.
    e0 = ferr_cnt;
    fork
      begin
        send_frame(32'h600, 8, 8);
        send_frame(32'h700, 8, 8);
        chk("b2b_blocked", 32'(s_ready), 0);
        t = 0;
        while (!s_ready && t < 200) begin
          @(posedge clk); #1;
          t++;
        end
        chk("b2b_gate_send", 32'(m_valid), 1);
        send_frame(32'h800, 8, 8);
      end
      begin
        run_core(32'h600, 30);
        consume(32'h600, 1'b0, 1'b0);
        run_core(32'h700, 0);
        consume(32'h700, 1'b0, 1'b0);
        run_core(32'h800, 0);
        consume(32'h800, 1'b0, 1'b0);
      end
    join
    chk("b2b_no_err", 32'(ferr_cnt - e0), 0);

    // Back-pressure with a write during SEND that must be ignored.
    fork
      send_frame(32'h900, 8, 8);
      begin
        run_core(32'h900, 0);
        consume(32'h900, 1'b1, 1'b1);
      end
    join

    // Reset in SEND after two beats.
    fork
      send_frame(32'h1, 8, 8);
      begin
        run_core(32'h1, 0);
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
          chk("pre_rst_data", m_data, 32'(k + 2));
          @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_last", 32'(m_last), 0);
        chk("mid_rst_err_count", 32'(err_count), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        m_ready = 1'b0;
      end
    join
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst2_s_ready", 32'(s_ready), 1);
    fork
      send_frame(32'h1, 8, 8);
      begin
        run_core(32'h1, 0);
        consume(32'h1, 1'b0, 1'b0);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_bridge.md
AXIS_FRAME_BRIDGE -- requirements
Module: axis_frame_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: stream word and buffer width.
REQ-002 The block SHALL have parameter IN_DATA_NUM, default 8: input words per frame, at least 2.
REQ-003 The block SHALL have parameter OUT_DATA_NUM, default 4: output words per frame, at least 2.
REQ-004 The block SHALL have derived parameters IN_ADR_W = clog2(IN_DATA_NUM) and OUT_ADR_W = clog2(OUT_DATA_NUM).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous active-high reset
- s_data  in  DATA_WIDTH  slave stream data
- s_valid  in  1  slave beat valid
- s_last  in  1  slave end of frame
- s_ready  out  1  slave ready
- m_data  out  DATA_WIDTH  master stream data
- m_valid  out  1  master beat valid
- m_last  out  1  master end of frame
- m_ready  in  1  master ready
- axisif_start  out  1  one-cycle compute start pulse
- axisif_done  in  1  core status level: 1 idle, 0 busy
- axisif_bufferIn_adr  in  IN_ADR_W  core read address
- axisif_bufferIn_data  out  DATA_WIDTH  combinational read of the active input bank
- axisif_bufferOut_adr  in  OUT_ADR_W  core write address
- axisif_bufferOut_data  in  DATA_WIDTH  core write data
- axisif_bufferOut_wr  in  1  core write enable
- frame_err  out  1  one-cycle malformed-frame pulse
- err_count  out  16  saturating malformed-frame count

Function
REQ-006 The input buffer SHALL be ping-pong: two banks of IN_DATA_NUM words, each either FREE or FULL; the write bank (wbank) and read bank (rbank) SHALL each toggle after use, so frames are processed in arrival order.
REQ-007 s_ready SHALL be 1 when bank[wbank] is FREE or a long-frame drain is in progress, and 0 otherwise.
REQ-008 An accepted beat (s_valid and s_ready) SHALL be written to bank[wbank][wcnt], and wcnt SHALL then increment.
REQ-009 A beat with wcnt = IN_DATA_NUM-1 and s_last = 1 SHALL commit the bank: the bank becomes FULL, wbank toggles, and wcnt returns to 0.
REQ-010 Short frame: a beat with s_last = 1 and wcnt < IN_DATA_NUM-1 SHALL discard the frame (bank stays FREE, wcnt = 0), pulse frame_err, and increment err_count.
REQ-011 Long frame: a beat with wcnt = IN_DATA_NUM-1 and s_last = 0 SHALL commit the bank, then enter drain.
- In drain, beats are accepted but discarded.
- The drain beat carrying s_last ends the drain, pulses frame_err and increments err_count.
REQ-012 err_count SHALL saturate at 0xFFFF.
REQ-013 The control FSM SHALL have states IDLE, START, ACK, RUN and SEND, with these transitions:
- IDLE -> START when bank[rbank] is FULL.
- START -> ACK unconditionally; axisif_start = 1 only in START.
- ACK -> RUN when axisif_done = 0.
- RUN -> SEND when axisif_done = 1; at that edge bank[rbank] becomes FREE and rbank toggles.
- SEND -> IDLE when the last output beat is accepted.
REQ-014 axisif_bufferIn_data SHALL equal bank[rbank][axisif_bufferIn_adr], combinationally.
REQ-015 axisif_bufferOut_wr SHALL write the output buffer only in ACK or RUN; writes in any other state SHALL be ignored.
REQ-016 In SEND, m_valid SHALL be 1 with m_data = outbuf[rd], and m_last = 1 exactly when rd = OUT_DATA_NUM-1.
REQ-017 rd SHALL advance on m_valid and m_ready; m_data and m_last SHALL stay stable while m_valid = 1 and m_ready = 0.
REQ-018 Input reception SHALL continue independently of FSM state; a bank freed and a bank committed in the same cycle SHALL both take effect.

Reset
REQ-019 While rst = 1:
- s_ready, m_valid, m_last, axisif_start, frame_err, err_count and m_data SHALL be 0.
- The FSM SHALL be in IDLE, both banks FREE, wbank, rbank, wcnt and rd 0, and drain clear.
REQ-020 Buffer contents SHALL NOT be reset.
REQ-021 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-022 A reset mid-frame or mid-SEND SHALL abandon all frames in flight.

Verification
REQ-023 Single frame: beats 1..8, s_last on the 8th; core writes j+2 at address j, j = 0..3 -> one start pulse; m_data 2,3,4,5 with m_last on 5; frame_err never asserted.
REQ-024 Back-to-back: three frames sent while the core holds done = 0 -> frames 1 and 2 are accepted; s_ready = 0 at the first beat of frame 3 until frame 1 reaches RUN -> SEND; frames are processed in order 1,2,3.
REQ-025 Short frame: s_last on the 5th beat -> frame_err pulses once, err_count = 1, no start; the next good frame processes normally.
REQ-026 Long frame: 10 beats, s_last on the 10th -> core reads words 1..8; beats 9 and 10 are dropped; frame_err pulses on beat 10; err_count increments by 1.
REQ-027 Back-pressure: m_ready alternating 0/1 -> exactly 4 beats transferred; m_data stable whenever m_valid = 1 and m_ready = 0.
REQ-028 Reset in SEND after 2 beats -> m_valid = 0 immediately and err_count = 0; the next full frame yields 2,3,4,5.
